// File: rtl/mips_cpu_arb_pkg.sv
// Shared types for the MIPS CPU Avalon arbiter.
//   arb_state_t : transfer sequencer states (IDLE -> BUSY -> GAP -> IDLE)
//   arb_owner_t : which CPU port owns the current/last transfer
//   BE_ALL      : byteenable driven for instruction fetches on a 32-bit bus
package mips_cpu_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, GAP} arb_state_t;
  typedef enum logic {OWN_INSTR, OWN_DATA} arb_owner_t;
  localparam logic [3:0] BE_ALL = 4'b1111;
endpackage

// File: rtl/mips_cpu_arb_select.sv
// Combinational grant logic for the arbiter.
//   i_req, d_req  : pending requests from the fetch and data ports
//   last_owner    : owner of the last completed transfer (ARB_ROUND_ROBIN_EN only)
//   grant_valid   : at least one request pending
//   grant         : port to serve next
// Build option ARB_ROUND_ROBIN_EN: on contention, grant the port that did not
// own the last transfer. Without it the data port always wins contention.
module mips_cpu_arb_select
  import mips_cpu_arb_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_t last_owner,
`endif
  output logic       grant_valid,
  output arb_owner_t grant
);
  always_comb begin
    grant_valid = i_req | d_req;
    grant       = d_req ? OWN_DATA : OWN_INSTR;
`ifdef ARB_ROUND_ROBIN_EN
    if (i_req && d_req)
      grant = (last_owner == OWN_DATA) ? OWN_INSTR : OWN_DATA;
`endif
  end
endmodule

// File: rtl/mips_cpu_avalon_arbiter.sv
// Shares one Avalon-MM master port between the CPU fetch port (read-only)
// and data port (read/write), one transaction at a time.
//   clk, reset        : clock, async active-high reset
//   i_req/i_addr      : fetch request, held until i_ack
//   i_ack/i_rdata     : 1-cycle ack, fetched word held until next i_ack
//   d_req/d_we/d_addr/d_be/d_wdata : data request, held until d_ack
//   d_ack/d_rdata     : 1-cycle ack, read word held until next read ack
//   err               : pulses with ack when the watchdog aborted the transfer
//   avm_*             : registered Avalon-MM master signals
// Build option ARB_ROUND_ROBIN_EN: alternate grants on contention instead of
// fixed data-port priority. TIMEOUT=0 disables the BUSY watchdog.
module mips_cpu_avalon_arbiter
  import mips_cpu_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata
);
  localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  arb_state_t         state, state_nxt;
  arb_owner_t         owner, grant;
  logic               grant_valid, done, abort, timeout_hit;
  logic [TIMER_W-1:0] timer;
`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_t         last_owner;
`endif

  mips_cpu_arb_select u_select (
    .i_req       (i_req),
    .d_req       (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner  (last_owner),
`endif
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Timer starts at 0 in the first BUSY cycle, so the hit lands on the
  // TIMEOUT-th BUSY cycle.
  assign timeout_hit = (TIMEOUT != 0) && (timer == TIMER_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: if (grant_valid) state_nxt = BUSY;
      BUSY: begin
        // A real completion wins over a watchdog hit on the same edge.
        if ((avm_read || avm_write) && !avm_waitrequest) begin
          done      = 1'b1;
          state_nxt = GAP;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner          <= OWN_INSTR;
      timer          <= '0;
      avm_address    <= '0;
      avm_byteenable <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      i_ack          <= 1'b0;
      d_ack          <= 1'b0;
      err            <= 1'b0;
      i_rdata        <= '0;
      d_rdata        <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner     <= OWN_INSTR;
`endif
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      err   <= 1'b0;
      if (state == IDLE && grant_valid) begin
        owner <= grant;
        timer <= '0;
        if (grant == OWN_DATA) begin
          avm_address    <= d_addr;
          avm_byteenable <= d_be;
          avm_writedata  <= d_wdata;
          avm_read       <= ~d_we;
          avm_write      <= d_we;
        end else begin
          avm_address    <= i_addr;
          avm_byteenable <= '1;
          avm_writedata  <= '0;
          avm_read       <= 1'b1;
          avm_write      <= 1'b0;
        end
      end
      if (state == BUSY) begin
        timer <= timer + 1'b1;
        if (done || abort) begin
          avm_read  <= 1'b0;
          avm_write <= 1'b0;
          err       <= abort;
          if (owner == OWN_DATA) d_ack <= 1'b1;
          else                   i_ack <= 1'b1;
          if (done && avm_read) begin
            if (owner == OWN_DATA) d_rdata <= avm_readdata;
            else                   i_rdata <= avm_readdata;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_owner <= owner;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_mips_cpu_avalon_arbiter.sv
// Self-checking bench for mips_cpu_avalon_arbiter (TIMEOUT=8).
// A small Avalon RAM slave with programmable waitrequest sits on the master
// port; a shadow memory plus per-port rdata/last-owner model gives expected
// values. Honors ARB_ROUND_ROBIN_EN when predicting contention order.
module tb_mips_cpu_avalon_arbiter;
  import mips_cpu_arb_pkg::*;
  localparam int TO = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_ack, d_req, d_we, d_ack, err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, avm_byteenable;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic        avm_read, avm_write, avm_waitrequest;

  int checks = 0, errors = 0;
  logic [31:0] mem [64];
  logic [31:0] shadow [64];
  int  wait_cycles = 0;
  int  cnt = 0;
  bit  stuck = 1'b0;
  logic [31:0] m_irdata, m_drdata;
  bit  m_last_d;
  logic        p_cmd = 1'b0, p_ack = 1'b0;
  logic [69:0] p_cmdvec = '0;

  always #5 clk = ~clk;

  mips_cpu_avalon_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
  );

  // RAM slave: waitrequest held for wait_cycles cycles of each command.
  assign avm_waitrequest = stuck || (cnt != 0);
  assign avm_readdata    = mem[avm_address[7:2]];
  always @(posedge clk) begin
    if (!(avm_read || avm_write)) cnt <= wait_cycles;
    else if (cnt != 0)            cnt <= cnt - 1;
    if (avm_write && !avm_waitrequest)
      for (int b = 0; b < 4; b++)
        if (avm_byteenable[b]) mem[avm_address[7:2]][8*b +: 8] <= avm_writedata[8*b +: 8];
  end

  function automatic logic [31:0] wa(input int idx);
    return 32'hBFC0_0000 | (32'(idx) << 2);
  endfunction

  function automatic bit pick_d(input bit ir, input bit dr, input bit last_d);
    if (ir && dr) return RR ? !last_d : 1'b1;
    return dr;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock step plus the per-cycle bus rules.
  task automatic tick();
    logic ack, cmd;
    @(negedge clk);
    ack = i_ack | d_ack;
    cmd = avm_read | avm_write;
    chk("rw_excl",    72'(avm_read & avm_write), 72'(0));
    chk("ack_onehot", 72'(i_ack & d_ack), 72'(0));
    chk("ack_repeat", 72'(ack & p_ack), 72'(0));
    chk("gap_cmd",    72'(ack & cmd), 72'(0));
    chk("err_w_ack",  72'(err & ~ack), 72'(0));
    if (p_cmd && cmd)
      chk("cmd_stable", 72'({avm_address, avm_byteenable, avm_writedata, avm_read, avm_write}),
          72'(p_cmdvec));
    p_cmd    = cmd;
    p_ack    = ack;
    p_cmdvec = {avm_address, avm_byteenable, avm_writedata, avm_read, avm_write};
  endtask

  task automatic wait_ack(output int cyc, output logic ia, output logic da, output logic er);
    cyc = 0; ia = 1'b0; da = 1'b0; er = 1'b0;
    while (cyc < 40 && !(ia || da)) begin
      tick();
      cyc++;
      ia = i_ack; da = d_ack; er = err;
    end
    chk("ack_seen", 72'(ia | da), 72'(1));
  endtask

  task automatic model_done(input bit is_d, input bit we, input int idx,
                            input logic [3:0] be, input logic [31:0] wd, input bit aborted);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (!aborted) begin
      if (is_d && we) shadow[idx] = (shadow[idx] & ~mask) | (wd & mask);
      else if (is_d)  m_drdata = shadow[idx];
      else            m_irdata = shadow[idx];
    end
    m_last_d = is_d;
  endtask

  task automatic one_xfer(input bit is_d, input bit we, input int idx, input logic [3:0] be,
                          input logic [31:0] wd, input int w, input bit stk);
    int cyc;
    logic ia, da, er;
    wait_cycles = w;
    stuck = stk;
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = wa(idx); d_be = be; d_wdata = wd; end
    else begin i_req = 1'b1; i_addr = wa(idx); end
    wait_ack(cyc, ia, da, er);
    chk("x_owner",   72'({ia, da}), 72'(is_d ? 2'b01 : 2'b10));
    chk("x_latency", 72'(cyc), 72'(stk ? TO + 1 : 2 + w));
    chk("x_err",     72'(er), 72'(stk));
    model_done(is_d, we, idx, be, wd, stk);
    chk("x_i_rdata", 72'(i_rdata), 72'(m_irdata));
    chk("x_d_rdata", 72'(d_rdata), 72'(m_drdata));
    i_req = 1'b0; d_req = 1'b0; stuck = 1'b0;
    tick();
    chk("x_ack_clr", 72'({i_ack, d_ack, err}), 72'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, w, base;
    logic ia, da, er;
    bit exp_d;
    logic [31:0] old4, v;

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_be = '0; d_wdata = '0;
    for (int k = 0; k < 64; k++) begin
      v = $urandom;
      mem[k] <= v;
      shadow[k] = v;
    end
    m_irdata = '0; m_drdata = '0; m_last_d = 1'b0;

    tick(); tick();
    chk("rst_ctrl",  72'({avm_read, avm_write, i_ack, d_ack, err}), 72'(0));
    chk("rst_addr",  72'(avm_address), 72'(0));
    chk("rst_be",    72'(avm_byteenable), 72'(0));
    chk("rst_wdata", 72'(avm_writedata), 72'(0));
    chk("rst_rdata", 72'({i_rdata, d_rdata}), 72'(0));
    reset = 1'b0;
    tick();

    // Zero-wait instruction fetch, cycle by cycle.
    i_req = 1'b1; i_addr = 32'hBFC0_0000; wait_cycles = 0;
    tick();
    chk("t1_cmd",   72'({avm_read, avm_write}), 72'(2'b10));
    chk("t1_addr",  72'(avm_address), 72'(32'hBFC0_0000));
    chk("t1_be",    72'(avm_byteenable), 72'(BE_ALL));
    chk("t1_noack", 72'(i_ack), 72'(0));
    tick();
    chk("t1_ack",      72'({i_ack, d_ack, err}), 72'(3'b100));
    chk("t1_rdata",    72'(i_rdata), 72'(shadow[0]));
    chk("t1_gap_read", 72'(avm_read), 72'(0));
    m_irdata = shadow[0]; m_last_d = 1'b0;
    i_req = 1'b0;
    tick();
    chk("t1_ack_clr", 72'(i_ack), 72'(0));
    chk("t1_hold",    72'(i_rdata), 72'(m_irdata));

    // Partial write with 3 wait cycles, then readback of word 4.
    old4 = shadow[4];
    one_xfer(1'b1, 1'b1, 4, 4'b0011, 32'hDEAD_BEEF, 3, 1'b0);
    one_xfer(1'b1, 1'b0, 4, 4'hF, 32'h0, 0, 1'b0);
    chk("t2_word4", 72'(d_rdata), 72'({old4[31:16], 16'hBEEF}));

    // Waitrequest drops on the last BUSY cycle before the watchdog, and one before.
    one_xfer(1'b0, 1'b0, 6, 4'h0, 32'h0, 7, 1'b0);
    one_xfer(1'b0, 1'b0, 2, 4'h0, 32'h0, 6, 1'b0);

    // Watchdog aborts (read and write), then normal service resumes.
    one_xfer(1'b0, 1'b0, 5, 4'h0, 32'h0, 0, 1'b1);
    one_xfer(1'b1, 1'b0, 5, 4'hF, 32'h0, 0, 1'b0);
    one_xfer(1'b1, 1'b1, 9, 4'hF, 32'h1234_5678, 0, 1'b1);
    one_xfer(1'b1, 1'b0, 9, 4'hF, 32'h0, 1, 1'b0);

    // Reset while BUSY: command drops asynchronously, no ack follows.
    stuck = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = wa(7); d_be = 4'hF;
    tick(); tick();
    chk("rb_busy", 72'(avm_read), 72'(1));
    #2 reset = 1'b1;
    #1;
    chk("rb_cmd",   72'({avm_read, avm_write}), 72'(0));
    chk("rb_ack",   72'({i_ack, d_ack, err}), 72'(0));
    chk("rb_rdata", 72'({i_rdata, d_rdata}), 72'(0));
    d_req = 1'b0; stuck = 1'b0;
    tick();
    reset = 1'b0;
    m_irdata = '0; m_drdata = '0; m_last_d = 1'b0;
    repeat (3) begin
      tick();
      chk("rb_noack", 72'({i_ack, d_ack, err}), 72'(0));
    end
    one_xfer(1'b1, 1'b0, 7, 4'hF, 32'h0, 2, 1'b0);

    // Contention: both ports held for 8 grants, then the data port goes quiet.
    base = 2;
    for (int t = 0; t < 14; t++) begin
      if (t < 8) begin
        if (!i_req) begin i_req = 1'b1; i_addr = wa(int'($urandom_range(0, 63))); end
        if (!d_req) begin
          d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
          d_addr = wa(int'($urandom_range(0, 63)));
          d_be = 4'($urandom); d_wdata = $urandom;
        end
      end
      if (!i_req && !d_req) break;
      w = int'($urandom_range(0, 7));
      wait_cycles = w;
      exp_d = pick_d(i_req, d_req, m_last_d);
      wait_ack(cyc, ia, da, er);
      chk("arb_owner",   72'({ia, da}), 72'(exp_d ? 2'b01 : 2'b10));
      chk("arb_latency", 72'(cyc), 72'(base + w));
      chk("arb_err",     72'(er), 72'(0));
      if (exp_d) model_done(1'b1, d_we, int'(d_addr[7:2]), d_be, d_wdata, 1'b0);
      else       model_done(1'b0, 1'b0, int'(i_addr[7:2]), 4'h0, 32'h0, 1'b0);
      chk("arb_i_rdata", 72'(i_rdata), 72'(m_irdata));
      chk("arb_d_rdata", 72'(d_rdata), 72'(m_drdata));
      if (exp_d) d_req = 1'b0;
      else       i_req = 1'b0;
      base = 3;
    end
    tick();
    chk("arb_idle", 72'({i_ack, d_ack, avm_read, avm_write}), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
